// File: rtl/three_ones_seq_detect_if.sv
// Serial data bundle for three_ones_seq_detect: stream bit, output enable and the detect flag.
interface three_ones_seq_detect_if;
    logic oe;
    logic in;
    logic detect;

    modport master (
        output oe,
        output in,
        input  detect
    );

    modport slave (
        input  oe,
        input  in,
        output detect
    );
endinterface

// File: rtl/three_ones_seq_detect.sv
// Moore detector that flags three or more consecutive 1s on a serial stream.
// The output enable gates the flag only; the run count keeps advancing underneath it.
module three_ones_seq_detect (
    input  logic                   clk,
    input  logic                   rst,
    three_ones_seq_detect_if.slave bus
);

    // Each state is the saturating count of consecutive 1s seen so far.
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_e;

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S0;
        if (bus.in) begin
            unique case (state_q)
                S0:      state_d = S1;
                S1:      state_d = S2;
                S2:      state_d = S3;
                S3:      state_d = S3;
                default: state_d = S0;
            endcase
        end
    end

    assign bus.detect = (state_q == S3) & bus.oe;

endmodule

// File: tb/tb_three_ones_seq_detect.sv
// Self-checking bench for three_ones_seq_detect: directed scenarios plus randomized stream
// compared against a run-length reference model.
module tb_three_ones_seq_detect;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   run;   // model: consecutive 1s sampled since last 0 or reset

    three_ones_seq_detect_if bus ();

    three_ones_seq_detect dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, take the edge, update the model, settle past the edge.
    task automatic tick(input logic r, input logic i, input logic o);
        rst    = r;
        bus.in = i;
        bus.oe = o;
        @(posedge clk);
        if (r)      run = 0;
        else if (i) run = run + 1;
        else        run = 0;
        #1;
    endtask

    function automatic logic model_detect();
        return (run >= 3) && (bus.oe === 1'b1);
    endfunction

    task automatic test_reset();
        logic exp_seq [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 2; k++) begin
            tick(1'b1, 1'b1, 1'b1);
            checks++;
            if (bus.detect !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: detect=%b expected 0", k, bus.detect);
            end
        end
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 1'b1, 1'b1);
            checks++;
            if (bus.detect !== exp_seq[k]) begin
                errors++;
                $display("FAIL reset_release[%0d]: detect=%b expected %b", k, bus.detect,
                         exp_seq[k]);
            end
        end
    endtask

    task automatic test_gating();
        tick(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 1'b1, 1'b0);
            checks++;
            if (bus.detect !== 1'b0) begin
                errors++;
                $display("FAIL gated[%0d]: detect=%b expected 0", k, bus.detect);
            end
        end
        bus.oe = 1'b1;
        #1;
        checks++;
        if (bus.detect !== 1'b1) begin
            errors++;
            $display("FAIL oe_raise: detect=%b expected 1", bus.detect);
        end
        bus.oe = 1'b0;
        #1;
        checks++;
        if (bus.detect !== 1'b0) begin
            errors++;
            $display("FAIL oe_drop: detect=%b expected 0", bus.detect);
        end
        bus.oe = 1'b1;
    endtask

    task automatic test_break();
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 1'b0, 1'b1);
            checks++;
            if (bus.detect !== 1'b0) begin
                errors++;
                $display("FAIL break[%0d]: detect=%b expected 0", k, bus.detect);
            end
        end
    endtask

    task automatic test_short_runs();
        logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tick(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, pat[k], 1'b1);
            checks++;
            if (bus.detect !== 1'b0) begin
                errors++;
                $display("FAIL short_run[%0d]: detect=%b expected 0", k, bus.detect);
            end
        end
    endtask

    task automatic test_exact_three();
        logic pat [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic exp [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, pat[k], 1'b1);
            checks++;
            if (bus.detect !== exp[k]) begin
                errors++;
                $display("FAIL exact_three[%0d]: detect=%b expected %b", k, bus.detect, exp[k]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic exp [3] = '{1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b1, 1'b1);
        checks++;
        if (bus.detect !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_pre: detect=%b expected 1", bus.detect);
        end
        tick(1'b1, 1'b1, 1'b1);
        checks++;
        if (bus.detect !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_edge: detect=%b expected 0", bus.detect);
        end
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b1, 1'b1);
            checks++;
            if (bus.detect !== exp[k]) begin
                errors++;
                $display("FAIL mid_reset_recount[%0d]: detect=%b expected %b", k, bus.detect,
                         exp[k]);
            end
        end
    endtask

    task automatic test_random();
        logic exp;
        for (int k = 0; k < 400; k++) begin
            tick(($urandom_range(31) == 0), ($urandom_range(3) != 0), ($urandom_range(3) != 0));
            exp = model_detect();
            checks++;
            if (bus.detect !== exp) begin
                errors++;
                $display("FAIL random[%0d]: detect=%b expected %b (run=%0d oe=%b)", k,
                         bus.detect, exp, run, bus.oe);
            end
            // Mid-cycle oe toggle must reach detect without an edge.
            if ($urandom_range(7) == 0) begin
                bus.oe = ~bus.oe;
                #1;
                exp = model_detect();
                checks++;
                if (bus.detect !== exp) begin
                    errors++;
                    $display("FAIL random_oe[%0d]: detect=%b expected %b", k, bus.detect, exp);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        run    = 0;
        rst    = 1'b1;
        bus.in = 1'b1;
        bus.oe = 1'b1;
        test_reset();
        test_gating();
        test_break();
        test_short_runs();
        test_exact_three();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/three_ones_seq_detect.md
# three_ones_seq_detect

Synchronous serial pattern detector that watches a one-bit input stream and flags every occurrence of three or more consecutive `1` samples. It is implemented as a small Moore state machine. An output-enable input gates the flag without disturbing detection state. It sits on a serial data path as a simple event/qualifier source for downstream control logic.

## Interface
Parameters: none. The pattern length is fixed at three.

Ports:
- `clk`  input  1  Single system clock; all state changes on the rising edge.
- `rst`  input  1  Reset, synchronous and active-high; sampled on the rising edge of `clk`.
- `oe`  input  1  Output enable. `1` lets `detect` reflect the detection state; `0` forces `detect` to `0`.
- `in`  input  1  Serial data bit, sampled on every rising edge of `clk`.
- `detect`  output  1  High while the last three sampled `in` bits were all `1` and `oe` is `1`.

## Operation
- The FSM has four states, each encoding the count of consecutive `1`s seen:
  - S0: none.
  - S1: one.
  - S2: two.
  - S3: three or more.
- Transitions on each rising edge when `rst` is `0`:
  - `in=1`: S0→S1, S1→S2, S2→S3, S3→S3 (saturates).
  - `in=0`: any state → S0.
- Detection is overlapping and sustained. A run of N≥3 ones keeps the FSM in S3 for N−2 consecutive cycles.
- `detect = (state == S3) & oe`. This is a pure combinational gate of the registered state; no extra register sits on `detect`.
- `oe` affects only the output. The FSM keeps counting while `oe=0`, so raising `oe` during a run already in S3 asserts `detect` immediately.
- `detect` is always driven to `0` or `1`, never high-Z.
- State encoding is an implementation choice. Unused encodings must recover to S0 on the next edge.

## Timing
- Reset:
  - `rst=1` at a rising edge → state becomes S0 regardless of `in`.
  - `detect` is `0` from that edge until the FSM next reaches S3.
  - Reset has priority over `in`.
  - Reset mid-run discards the partial count.
- Latency:
  - `detect` rises after the rising edge that samples the third consecutive `1`. That is one cycle after the sample, with no further pipeline.
  - `detect` falls after the first edge that samples `in=0`.
- `oe` changes propagate combinationally to `detect` within the same cycle.
- `in` and `oe` must meet setup/hold to `clk`. No handshake.

## Test plan
- Reset with `in=1`, `oe=1` for two edges:
  - Then release `rst`.
  - `detect=0` during reset.
  - `detect=0` after edges 1 and 2 post-reset.
  - `detect=1` after edge 3 and stays `1` while `in=1`.
- Output gating:
  - Hold `in=1`, `oe=0` for 5 edges after reset → `detect=0` throughout.
  - Raise `oe` → `detect=1` in the same cycle, with no extra count needed.
- Break on zero:
  - From S3, drive `in=0` for 5 edges → `detect=0` after the first `0` edge and remains `0`.
- Short runs rejected: the pattern 1,0,1,1,0 (one edge per bit) → `detect` stays `0` throughout.
- Exact-three run:
  - `in` = 1,1,1,0 → `detect=1` for exactly one cycle, after the third `1` edge.
  - `detect=0` after the `0` edge.
- Synchronous reset mid-run:
  - Assert `rst` for one edge while in S3 → `detect=0` after that edge.
  - With `in=1` held, three more edges are required before `detect=1` again.
